// File: rtl/scratch_pkg.sv
// Shared constants and types for the MCU scratch RAM arbiter.
package scratch_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 10;
  localparam int RAM_DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } scr_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/scratch_ram_arbiter.sv
// Scratch RAM arbiter: shares one RAM port between the CPU datapath and a
// secondary requester (port B), and zeroes the whole RAM after reset or on
// command. Port B is starved for at most MAX_WAIT cycles before it is forced
// in ahead of the CPU; MAX_WAIT = 0 gives port B strict priority.
module scratch_ram_arbiter
  import scratch_pkg::*;
#(
  parameter int ADDR_W   = scratch_pkg::ADDR_W,
  parameter int DATA_W   = scratch_pkg::DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DIN,
  output logic [DATA_W-1:0] CPU_DOUT,
  output logic              CPU_STALL,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DIN,
  output logic              B_GNT,
  output logic [DATA_W-1:0] B_RDATA,
  output logic              B_RVALID,
  input  logic              CLR_START,
  output logic              CLR_BUSY,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DIN,
  input  logic [DATA_W-1:0] RAM_DOUT
);

  // Age counter must be able to hold MAX_WAIT; keep at least one bit so the
  // MAX_WAIT = 0 (B priority) configuration still elaborates.
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

  scr_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              grant_b;

  // Port B wins when the CPU is idle or when B has already waited its limit.
  assign grant_b = (state == RUN) && B_REQ && (!CPU_REQ || (wait_cnt == WAIT_LIMIT));

  // CPU read data is the raw RAM output; it is only meaningful when the CPU
  // request is being served this cycle.
  assign CPU_DOUT = RAM_DOUT;

  // Clear sequencer, port B age counter and registered port B read data.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLEAR;
      clr_addr <= '0;
      wait_cnt <= '0;
      B_RDATA  <= '0;
      B_RVALID <= 1'b0;
    end else begin
      B_RVALID <= 1'b0;
      case (state)
        CLEAR: begin
          // CLR_START is deliberately ignored here: a clear never restarts
          // itself, only RST does.
          clr_addr <= clr_addr + 1'b1;
          wait_cnt <= '0;
          if (clr_addr == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (grant_b && !B_WE) begin
            B_RDATA  <= RAM_DOUT;
            B_RVALID <= 1'b1;
          end
          if (!B_REQ || grant_b) begin
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          // The current cycle has already been arbitrated normally above;
          // the clear takes over the RAM port from the next cycle.
          if (CLR_START) begin
            state    <= CLEAR;
            clr_addr <= '0;
            wait_cnt <= '0;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // RAM port mux: clear sequencer, port B or CPU drives the single RAM port.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    RAM_WE    = 1'b0;
    RAM_ADDR  = CPU_ADDR;
    RAM_DIN   = CPU_DIN;
    CPU_STALL = 1'b0;
    B_GNT     = 1'b0;
    CLR_BUSY  = 1'b0;
    if (state == CLEAR) begin
      RAM_WE    = 1'b1;
      RAM_ADDR  = clr_addr;
      RAM_DIN   = '0;
      CPU_STALL = CPU_REQ;
      CLR_BUSY  = 1'b1;
    end else if (grant_b) begin
      RAM_WE    = B_WE;
      RAM_ADDR  = B_ADDR;
      RAM_DIN   = B_DIN;
      B_GNT     = 1'b1;
      CPU_STALL = CPU_REQ;
    end else begin
      RAM_WE = CPU_REQ && CPU_WE;
    end
  end

endmodule

// File: tb/tb_scratch_ram_arbiter.sv
// Directed self-checking bench for scratch_ram_arbiter, with a behavioural
// 256 x 10 RAM (combinational read, synchronous write) attached.
module tb_scratch_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr;
  logic [9:0] cpu_din, cpu_dout;
  logic       cpu_stall;
  logic       b_req, b_we;
  logic [7:0] b_addr;
  logic [9:0] b_din, b_rdata;
  logic       b_gnt, b_rvalid;
  logic       clr_start, clr_busy;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [9:0] ram_din, ram_dout;

  logic [9:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scratch_ram_arbiter #(.ADDR_W(8), .DATA_W(10), .MAX_WAIT(4)) dut (
    .CLK(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din),
    .CPU_DOUT(cpu_dout), .CPU_STALL(cpu_stall),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_DIN(b_din),
    .B_GNT(b_gnt), .B_RDATA(b_rdata), .B_RVALID(b_rvalid),
    .CLR_START(clr_start), .CLR_BUSY(clr_busy),
    .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_DIN(ram_din), .RAM_DOUT(ram_dout)
  );

  // Behavioural scratch RAM, preloaded with non-zero garbage so the clear
  // sequence is observable.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 10'h3FF ^ 10'(i);
  end
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // combinational outputs settle 1 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_din = 0; clr_start = 0;
  endtask

  int n;
  logic all_ok;

  initial begin
    rst = 1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 0;

    // Power-on clear: 256 zero writes at ascending addresses; CPU stalled,
    // B refused, CLR_START ignored throughout.
    for (int i = 0; i < 256; i++) begin
      cpu_req   = ((i % 64) == 10);
      b_req     = (i == 20);
      clr_start = (i == 50);
      #1;
      check($sformatf("clear_cyc%0d", i),
            {clr_busy, ram_we, ram_addr, ram_din, cpu_stall, b_gnt},
            {1'b1, 1'b1, 8'(i), 10'h000, cpu_req, 1'b0});
      next_cycle();
      idle_inputs();
    end

    // RUN: CPU reads cleared location 0x10.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1;
    check("run_busy", clr_busy, 0);
    check("cpu_rd_cleared", cpu_dout, 10'h000);
    check("cpu_rd_stall", cpu_stall, 0);
    check("cpu_rd_we", ram_we, 0);
    next_cycle();

    // CPU write then read back same address.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_din = 10'h155;
    #1;
    check("cpu_wr_we", ram_we, 1);
    check("cpu_wr_stall", cpu_stall, 0);
    next_cycle();
    cpu_we = 0;
    #1;
    check("cpu_rd_back", cpu_dout, 10'h155);
    check("cpu_rd_back_stall", cpu_stall, 0);
    next_cycle();

    // Port B read with CPU idle.
    idle_inputs();
    b_req = 1; b_addr = 8'h20;
    #1;
    check("b_rd_gnt", b_gnt, 1);
    check("b_rd_rvalid_early", b_rvalid, 0);
    next_cycle();
    b_req = 0;
    #1;
    check("b_rd_rvalid", b_rvalid, 1);
    check("b_rd_data", b_rdata, 10'h155);
    next_cycle();
    #1;
    check("b_rd_rvalid_pulse", b_rvalid, 0);
    check("b_rd_data_hold", b_rdata, 10'h155);

    // Port B write, then CPU reads it the next cycle; writes give no RVALID.
    b_req = 1; b_we = 1; b_addr = 8'h30; b_din = 10'h2AA;
    #1;
    check("b_wr_gnt", b_gnt, 1);
    check("b_wr_we", ram_we, 1);
    check("b_wr_din", ram_din, 10'h2AA);
    next_cycle();
    idle_inputs();
    cpu_req = 1; cpu_addr = 8'h30;
    #1;
    check("b_wr_no_rvalid", b_rvalid, 0);
    check("cpu_rd_after_b_wr", cpu_dout, 10'h2AA);
    next_cycle();

    // Contention: CPU holds its request, B is refused 4 cycles then forced in.
    cpu_req = 1; cpu_addr = 8'h20;
    b_req = 1; b_we = 0; b_addr = 8'h30;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("age_deny%0d", c), {b_gnt, cpu_stall}, 2'b00);
      next_cycle();
    end
    #1;
    check("age_force_gnt", {b_gnt, cpu_stall}, 2'b11);
    check("age_force_addr", ram_addr, 8'h30);
    next_cycle();
    b_req = 0;
    #1;
    check("age_cpu_served", {b_gnt, cpu_stall}, 2'b00);
    check("age_cpu_data", cpu_dout, 10'h155);
    check("age_b_rvalid", b_rvalid, 1);
    check("age_b_rdata", b_rdata, 10'h2AA);
    next_cycle();

    // CLR_START while B is held: the start cycle arbitrates normally (CPU),
    // then 256 clear cycles refuse B, then B is granted in the first RUN cycle.
    idle_inputs();
    cpu_req = 1; cpu_addr = 8'h20;
    b_req = 1; b_addr = 8'h20;
    clr_start = 1;
    #1;
    check("clr_start_cycle", {clr_busy, b_gnt, cpu_stall}, 3'b000);
    next_cycle();
    clr_start = 0; cpu_req = 0;
    all_ok = 1;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (!(clr_busy === 1 && b_gnt === 0 && ram_addr === 8'(i))) all_ok = 0;
      next_cycle();
    end
    check("clr2_busy_256", all_ok, 1);
    #1;
    check("clr2_done", clr_busy, 0);
    check("clr2_b_gnt", b_gnt, 1);
    next_cycle();
    b_req = 0;
    #1;
    check("clr2_b_rvalid", b_rvalid, 1);
    check("clr2_b_rdata_zero", b_rdata, 10'h000);
    next_cycle();

    // Reset in the middle of a clear restarts it from address 0.
    clr_start = 1;
    next_cycle();
    clr_start = 0;
    for (int i = 0; i < 100; i++) next_cycle();
    #1;
    check("midclr_addr100", ram_addr, 8'd100);
    rst = 1;
    next_cycle();
    rst = 0;
    #1;
    check("midclr_restart_addr", ram_addr, 8'h00);
    n = 0;
    while (clr_busy === 1'b1 && n < 300) begin
      n++;
      next_cycle();
    end
    check("midclr_busy_cycles", n, 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
